// File: rtl/seg_scan_decoder_if.sv
// Bus between a multiplexed 7-segment display scanner and the decoder that
// reconstructs the displayed 4-digit value.
interface seg_scan_decoder_if;
   logic [6:0]  seg;
   logic [3:0]  an;
   logic [13:0] number;
   logic        valid;
   logic        err;

   modport master (
      output seg,
      output an,
      input  number,
      input  valid,
      input  err
   );

   modport slave (
      input  seg,
      input  an,
      output number,
      output valid,
      output err
   );
endinterface

// File: rtl/seg_scan_decoder.sv
// Watches a multiplexed active-low 7-segment bus, debounces each digit, and
// converts a complete set of four digits into a binary number.
//
// state   | meaning
// CAPTURE | collecting stable digits into slots until all four flags are set
// CONVERT | four cycles of acc = acc*10 + slot, most significant digit first
// DONE    | number/valid presented, flags cleared, back to CAPTURE
module seg_scan_decoder #(
   parameter int STABLE_CYCLES = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   seg_scan_decoder_if.slave  bus
);

   typedef enum logic [1:0] {
      CAPTURE = 2'd0,
      CONVERT = 2'd1,
      DONE    = 2'd2
   } state_t;

   localparam logic [5:0] ACCEPT_CNT = 6'(STABLE_CYCLES - 1);
   localparam logic [5:0] CNT_MAX    = 6'd63;

   state_t      state;
   state_t      state_nxt;

   logic [10:0] sync1;
   logic [10:0] sync2;
   logic [10:0] prev;
   logic [5:0]  cnt;
   logic [5:0]  cnt_nxt;

   logic        selecting;
   logic [1:0]  sel_idx;
   logic [3:0]  dec_digit;
   logic        dec_ok;
   logic        accept;
   logic        capture_en;

   logic [3:0]  slot [4];
   logic [3:0]  flags;
   logic [3:0]  flags_nxt;
   logic [13:0] acc;
   logic [13:0] acc_nxt;
   logic [1:0]  step;
   logic [13:0] number_q;
   logic        valid_q;
   logic        err_q;

   assign bus.number = number_q;
   assign bus.valid  = valid_q;
   assign bus.err    = err_q;

   always_comb begin
      selecting = 1'b1;
      sel_idx   = 2'd0;
      case (sync2[10:7])
         4'b1110: sel_idx = 2'd0;
         4'b1101: sel_idx = 2'd1;
         4'b1011: sel_idx = 2'd2;
         4'b0111: sel_idx = 2'd3;
         default: selecting = 1'b0;
      endcase
   end

   always_comb begin
      dec_ok    = 1'b1;
      dec_digit = 4'd0;
      case (sync2[6:0])
         7'h40:   dec_digit = 4'd0;
         7'h79:   dec_digit = 4'd1;
         7'h24:   dec_digit = 4'd2;
         7'h30:   dec_digit = 4'd3;
         7'h19:   dec_digit = 4'd4;
         7'h12:   dec_digit = 4'd5;
         7'h02:   dec_digit = 4'd6;
         7'h78:   dec_digit = 4'd7;
         7'h00:   dec_digit = 4'd8;
         7'h10:   dec_digit = 4'd9;
         default: dec_ok = 1'b0;
      endcase
   end

   // Acceptance fires on the cycle the counter steps onto ACCEPT_CNT, so a
   // long dwell passes that value only once.
   always_comb begin
      cnt_nxt = cnt;
      if (sync2 != prev) begin
         cnt_nxt = 6'd0;
      end else if (cnt != CNT_MAX) begin
         cnt_nxt = cnt + 6'd1;
      end
   end

   assign accept     = selecting && (cnt_nxt == ACCEPT_CNT);
   assign capture_en = accept && (state == CAPTURE);
   assign acc_nxt    = (acc << 3) + (acc << 1) + {10'd0, slot[~step]};

   always_comb begin
      flags_nxt = flags;
      if (state == DONE) begin
         flags_nxt = 4'd0;
      end else if (capture_en && dec_ok) begin
         flags_nxt[sel_idx] = 1'b1;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         CAPTURE: if (flags_nxt == 4'hF) state_nxt = CONVERT;
         CONVERT: if (step == 2'd3) state_nxt = DONE;
         DONE:    state_nxt = CAPTURE;
         default: state_nxt = CAPTURE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= CAPTURE;
      end else begin
         state <= state_nxt;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync1    <= '1;
         sync2    <= '1;
         prev     <= '1;
         cnt      <= '0;
         flags    <= '0;
         acc      <= '0;
         step     <= '0;
         number_q <= '0;
         valid_q  <= 1'b0;
         err_q    <= 1'b0;
         for (int i = 0; i < 4; i++) begin
            slot[i] <= '0;
         end
      end else begin
         sync1   <= {bus.an, bus.seg};
         sync2   <= sync1;
         prev    <= sync2;
         cnt     <= cnt_nxt;
         flags   <= flags_nxt;
         err_q   <= capture_en && !dec_ok;
         valid_q <= 1'b0;

         if (capture_en && dec_ok) begin
            slot[sel_idx] <= dec_digit;
         end

         if (state == CAPTURE && state_nxt == CONVERT) begin
            acc  <= '0;
            step <= '0;
         end else if (state == CONVERT) begin
            acc  <= acc_nxt;
            step <= step + 2'd1;
            // Final step publishes directly so number and valid land together.
            if (step == 2'd3) begin
               number_q <= acc_nxt;
               valid_q  <= 1'b1;
            end
         end
      end
   end

endmodule

// File: doc/seg_scan_decoder.md
SEG_SCAN_DECODER -- requirements
Module: seg_scan_decoder

Interface
REQ-001 Parameter: STABLE_CYCLES, default 8, number of consecutive identical samples required to accept a digit (range 2..63).
REQ-002 clk  input  1  single clock; every register updates on its rising edge only.
REQ-003 rst_n  input  1  reset, synchronous and active-low.
REQ-004 seg  input  7  active-low segment bus; seg[0]=a ... seg[6]=g.
REQ-005 an  input  4  active-low digit enables; an[k]=0 selects digit k, where k=0 is the least-significant digit.
REQ-006 number  output  14  last reconstructed binary value, registered.
REQ-007 valid  output  1  one-cycle pulse; number is updated in the same cycle.
REQ-008 err  output  1  one-cycle pulse on rejection of a stable but undecodable pattern.

Function
REQ-009 The block SHALL sample seg and an into a 2-flop synchroniser; all later logic SHALL use the second stage only.
REQ-010 A sample is "selecting" when exactly one bit of an is 0; an=4'b1111 or multiple zeros SHALL be treated as blank.
REQ-011 A 6-bit stability counter SHALL reset to 0 whenever the synchronised {an,seg} differs from the previous cycle, and otherwise increment, saturating at 63.
REQ-012 The counter reaching STABLE_CYCLES-1 while selecting SHALL constitute one acceptance event; at most one acceptance SHALL occur per unchanged dwell.
REQ-013 Decode table (seg hex -> digit): 40->0, 79->1, 24->2, 30->3, 19->4, 12->5, 02->6, 78->7, 00->8, 10->9.
REQ-014 On acceptance with a pattern in the table: store the digit in slot k and set flag[k]; an existing slot value SHALL be overwritten (latest wins).
REQ-015 On acceptance with a pattern not in the table: pulse err for one cycle; slot k and flag[k] SHALL be unchanged.
REQ-016 FSM states: CAPTURE, CONVERT, DONE.
REQ-017 CAPTURE -> CONVERT on the edge at which all four flags become set.
REQ-018 CONVERT SHALL last exactly 4 cycles, computing acc <= acc*10 + slot[3-i] for i=0..3 with acc starting at 0.
REQ-019 acc SHALL be 14 bits; the maximum result of 9999 fits without overflow.
REQ-020 DONE (1 cycle): number <= acc, valid=1, all flags cleared; then return to CAPTURE.
REQ-021 In CONVERT and DONE, acceptance events SHALL be ignored (no slot writes, no err); the stability counter SHALL keep running.
REQ-022 valid SHALL be high in the 5th cycle after the accepting edge of the last missing digit.
REQ-023 number SHALL hold its value between valid pulses.
REQ-024 Simultaneous completion and invalid pattern: cannot occur, since the err path never sets a flag.

Reset
REQ-025 While rst_n=0 at an edge: number=0, valid=0, err=0, flags=0, slots=0, acc=0, stability counter=0, synchroniser=all ones (blank), state=CAPTURE.
REQ-026 Reset during CONVERT or DONE SHALL abort the conversion; no valid pulse SHALL follow.

Verification
REQ-027 Scan 1234 (digits 4,3,2,1 on an 1110,1101,1011,0111), 80-cycle dwell with 10 blank cycles between -> one valid pulse, number=1234, err never set.
REQ-028 Scan 9999 then 0000 continuously -> successive valid pulses with number=9999, then number=0; no intermediate mixed value once a full 0000 cycle completes.
REQ-029 an=1110 with seg=7'h79 held 5 cycles, then changed -> no acceptance, flag[0] remains 0.
REQ-030 an=1011 with seg=7'h7F held 20 cycles -> err high exactly once, slot 2 unchanged, no valid.
REQ-031 Drop rst_n for 1 cycle, 2 cycles after entering CONVERT -> valid stays 0, number=0; a full rescan of 0042 -> number=42.
REQ-032 STABLE_CYCLES=2 with a 3-cycle dwell per digit -> 5678 decoded correctly.
